// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : fifo_pkg                                                     |
// | Desc     : Shared FIFO defaults and the occupancy-counter width helper. |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_DAT_WIDTH  = 10;
   localparam int DEF_ADDR_WIDTH = 4;

   // The counter needs one extra bit so that "full" (== DEPTH) is representable
   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : fifo_ram                                                     |
// | Desc     : DEPTH x DAT_WIDTH register array, one synchronous write port |
// |            and one registered, read-enabled read port.                  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DAT_WIDTH-1:0]  wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DAT_WIDTH-1:0]  rdata
);

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;

   logic [DAT_WIDTH-1:0] r_mem [0:c_DEPTH-1];
   logic [DAT_WIDTH-1:0] r_rdata;

   // Storage is deliberately not reset; logical emptiness lives in the counter
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Output register only moves on an accepted read, otherwise it holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : fifo_sync_param                                              |
// | Desc     : Parametrised single-clock FIFO with occupancy count,         |
// |            almost flags, read-valid strobe, sticky error flags and a    |
// |            synchronous clear.                                           |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                    Pclk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr,
   input  logic [DAT_WIDTH-1:0]    data_in,
   input  logic                    rd,
   output logic [DAT_WIDTH-1:0]    data_out,
   output logic                    rd_valid,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_empty,
   output logic                    almost_full,
   output logic [ADDR_WIDTH:0]     count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int                  c_CNT_W   = count_width(ADDR_WIDTH);
   localparam logic [c_CNT_W-1:0]  c_DEPTH   = c_CNT_W'(2 ** ADDR_WIDTH);
   localparam logic [c_CNT_W-1:0]  c_AF      = c_CNT_W'(AF_LEVEL);
   localparam logic [c_CNT_W-1:0]  c_AE      = c_CNT_W'(AE_LEVEL);
   localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_rd_valid;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_wr_ok;
   logic                  w_rd_ok;

   // Flags decode the registered count so they move on the same edge as count
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_DEPTH);

   // clr outranks both requests so that a write in the clear cycle is dropped
   assign w_wr_ok = wr & ~w_full  & ~clr;
   assign w_rd_ok = rd & ~w_empty & ~clr;

   // Pointers wrap naturally at ADDR_WIDTH bits; count alone decides full/empty
   always_ff @(posedge Pclk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
   end

   // Occupancy: a simultaneous accepted read and write cancel out
   always_ff @(posedge Pclk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else begin
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags and the read-valid strobe
   always_ff @(posedge Pclk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
      end else if (clr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
      end else begin
         if (wr & w_full)  r_overflow  <= 1'b1;
         if (rd & w_empty) r_underflow <= 1'b1;
         r_rd_valid <= w_rd_ok;
      end
   end

   fifo_ram #(
      .DAT_WIDTH  (DAT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (Pclk),
      .rst   (rst),
      .we    (w_wr_ok),
      .waddr (r_wr_ptr),
      .wdata (data_in),
      .re    (w_rd_ok),
      .raddr (r_rd_ptr),
      .rdata (data_out)
   );

   assign rd_valid     = r_rd_valid;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= c_AE);
   assign almost_full  = (r_count >= c_AF);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_fifo_sync_param                                           |
// | Desc     : Self-checking bench for fifo_sync_param against a queue      |
// |            reference model, directed scenarios plus random traffic.     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

   localparam int DW    = 10;
   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int AFL   = 3;
   localparam int AEL   = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          wr;
   logic [DW-1:0] din;
   logic          rd;
   logic [DW-1:0] dout;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic          aempty;
   logic          afull;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_q[$];
   int m_dout;
   int m_rv;
   int m_ov;
   int m_uf;

   fifo_sync_param #(
      .DAT_WIDTH  (DW),
      .ADDR_WIDTH (AW),
      .AF_LEVEL   (AFL),
      .AE_LEVEL   (AEL)
   ) dut (
      .Pclk         (clk),
      .rst          (rst),
      .clr          (clr),
      .wr           (wr),
      .data_in      (din),
      .rd           (rd),
      .data_out     (dout),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .full         (full),
      .almost_empty (aempty),
      .almost_full  (afull),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = 0;
      m_rv   = 0;
      m_ov   = 0;
      m_uf   = 0;
   endtask

   // One clock edge of FIFO behaviour, from the rules on pre-edge occupancy
   task automatic model_step(input bit w, input int d, input bit r, input bit c);
      int  n;
      bit  is_full;
      bit  is_empty;
      n        = m_q.size();
      is_full  = (n == DEPTH);
      is_empty = (n == 0);
      if (c) begin
         m_q.delete();
         m_rv = 0;
         m_ov = 0;
         m_uf = 0;
      end else begin
         if (w && is_full)  m_ov = 1;
         if (r && is_empty) m_uf = 1;
         if (r && !is_empty) begin
            m_dout = m_q.pop_front();
            m_rv   = 1;
         end else begin
            m_rv = 0;
         end
         if (w && !is_full) m_q.push_back(d);
      end
   endtask

   task automatic check_all(input string ctx);
      int n;
      n = m_q.size();
      chk({ctx, ":data_out"},  32'(dout),      32'(m_dout));
      chk({ctx, ":rd_valid"},  32'(rd_valid),  32'(m_rv));
      chk({ctx, ":count"},     32'(count),     32'(n));
      chk({ctx, ":empty"},     32'(empty),     32'(n == 0));
      chk({ctx, ":full"},      32'(full),      32'(n == DEPTH));
      chk({ctx, ":aempty"},    32'(aempty),    32'(n <= AEL));
      chk({ctx, ":afull"},     32'(afull),     32'(n >= AFL));
      chk({ctx, ":overflow"},  32'(overflow),  32'(m_ov));
      chk({ctx, ":underflow"}, 32'(underflow), 32'(m_uf));
   endtask

   // Drive one cycle of inputs, clock it, then compare away from the edge
   task automatic cyc(input string ctx, input bit w, input int d, input bit r, input bit c);
      wr  = w;
      din = DW'(d);
      rd  = r;
      clr = c;
      @(posedge clk);
      model_step(w, d, r, c);
      #1;
      check_all(ctx);
   endtask

   // Asynchronous reset between edges: outputs must change without a clock
   task automatic async_reset(input string ctx);
      #3;
      rst = 1'b1;
      wr  = 1'b0;
      rd  = 1'b0;
      clr = 1'b0;
      #1;
      model_reset();
      check_all(ctx);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int exp_words[4];
      rst = 1'b1;
      clr = 1'b0;
      wr  = 1'b0;
      rd  = 1'b0;
      din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Idle, then a read of an empty FIFO
      cyc("idle", 0, 0, 0, 0);
      cyc("rd_empty", 0, 0, 1, 0);
      chk("rd_empty:uf_const", 32'(underflow), 32'd1);

      // Fill, overflow attempt, drain
      exp_words = '{10'h3FF, 10'h2AA, 10'h3E0, 10'h155};
      foreach (exp_words[i]) cyc("fill", 1, exp_words[i], 0, 0);
      chk("fill:full_const", 32'(full), 32'd1);
      cyc("overfill", 1, 10'h001, 0, 0);
      chk("overfill:ov_const", 32'(overflow), 32'd1);
      foreach (exp_words[i]) begin
         cyc("drain", 0, 0, 1, 0);
         chk("drain:word_const", 32'(dout), 32'(exp_words[i]));
      end

      // Steady state at count 2 with wrapping pointers
      cyc("pre2", 1, 10'h011, 0, 0);
      cyc("pre2", 1, 10'h022, 0, 0);
      for (int i = 0; i < 10; i++) cyc("stream", 1, 10'h100 + i, 1, 0);
      chk("stream:count_const", 32'(count), 32'd2);

      // Simultaneous wr/rd at the empty and full boundaries
      cyc("drain2", 0, 0, 1, 0);
      cyc("drain2", 0, 0, 1, 0);
      async_reset("rst_clean");
      cyc("wrrd_empty", 1, 10'h0AB, 1, 0);
      for (int i = 0; i < 3; i++) cyc("fill4", 1, 10'h1C0 + i, 0, 0);
      cyc("wrrd_full", 1, 10'h3C3, 1, 0);
      chk("wrrd_full:count_const", 32'(count), 32'd3);

      // Clear with a write in the same cycle
      cyc("clr_wr", 1, 10'h2F2, 0, 1);
      chk("clr_wr:count_const", 32'(count), 32'd0);

      // Reset in the middle of a burst
      cyc("burst", 1, 10'h050, 0, 0);
      cyc("burst", 1, 10'h051, 1, 0);
      async_reset("rst_mid");

      // Random traffic with occasional clear and reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
         cyc("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_sync_param
`default_nettype wire
